tour_cmd_seq: RTL

Sequences the knight's-tour replay into the command processor. In idle it passes UART commands straight through to `cmd_proc`. When `tour_go` fires, it takes over the command port and walks a stored solution of one-hot knight moves. Each L-move is split into two straight legs, issued with the `cmd_rdy`/`clr_cmd_rdy` handshake, and a progress or completion byte is returned on the UART response path.

---
 rtl/tour_pkg.sv | 42 ++++
 rtl/knight_move_decode.sv | 35 +++
 rtl/tour_cmd_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tour_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tour_pkg
//  Brief    : Shared types and constants for the knight's-tour command
//             sequencer (states, opcodes, headings, response bytes, leg type).
//  Revision : 1.0  initial release
// ============================================================================
package tour_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEG1  = 3'd1,
        WAIT1 = 3'd2,
        LEG2  = 3'd3,
        WAIT2 = 3'd4,
        NEXT  = 3'd5,
        RESP  = 3'd6
    } state_t;

    localparam logic [3:0] CAL     = 4'h2;
    localparam logic [3:0] MOVE    = 4'h4;
    localparam logic [3:0] MOVE_FF = 4'h5;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [7:0] RESP_DONE  = 8'hA5;
    localparam logic [7:0] RESP_PROG  = 8'h5A;
    localparam logic [7:0] RESP_ABORT = 8'hEE;

    localparam logic [3:0] SQ_LEG1 = 4'd2;
    localparam logic [3:0] SQ_LEG2 = 4'd1;

    typedef struct packed {
        logic [7:0] heading;
        logic [3:0] squares;
    } leg_t;

endpackage
`default_nettype wire

// File: rtl/knight_move_decode.sv
`default_nettype none
// ============================================================================
//  Module   : knight_move_decode
//  Brief    : Splits a one-hot knight move into its two straight legs and
//             flags whether the move code is legal (exactly one bit set).
//  Revision : 1.0  initial release
// ============================================================================
module knight_move_decode
    import tour_pkg::*;
(
    input  logic [7:0] move,
    output leg_t       leg1,
    output leg_t       leg2,
    output logic       legal
);

    always_comb begin
        leg1  = '{heading: HDG_N, squares: SQ_LEG1};
        leg2  = '{heading: HDG_N, squares: SQ_LEG2};
        legal = (move != 8'h00) && ((move & (move - 8'h01)) == 8'h00);
        case (move)
            8'h01: begin leg1.heading = HDG_N; leg2.heading = HDG_W; end
            8'h02: begin leg1.heading = HDG_N; leg2.heading = HDG_E; end
            8'h04: begin leg1.heading = HDG_W; leg2.heading = HDG_N; end
            8'h08: begin leg1.heading = HDG_W; leg2.heading = HDG_S; end
            8'h10: begin leg1.heading = HDG_S; leg2.heading = HDG_W; end
            8'h20: begin leg1.heading = HDG_S; leg2.heading = HDG_E; end
            8'h40: begin leg1.heading = HDG_E; leg2.heading = HDG_S; end
            8'h80: begin leg1.heading = HDG_E; leg2.heading = HDG_N; end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/tour_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tour_cmd_seq
//  Brief    : Passes UART commands to cmd_proc when idle; on tour_go replays
//             the stored knight's tour as two-leg move commands.
//             Define TOUR_PROGRESS_RESP_EN to emit a 0x5A byte per move.
//  Revision : 1.0  initial release
// ============================================================================
module tour_cmd_seq
    import tour_pkg::*;
#(
    parameter int DEPTH = 24,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tour_go,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic             clr_cmd_rdy_UART,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [7:0]       resp,
    output logic             trmt
);

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] c_ONE  = IDX_W'(1);

    state_t           r_state, w_nxt;
    logic [IDX_W-1:0] r_idx, w_nxt_idx;
    logic [7:0]       r_resp, w_nxt_resp;
    logic             r_trmt;
    leg_t             w_leg1, w_leg2;
    logic             w_legal;

    knight_move_decode u_decode (
        .move  (move),
        .leg1  (w_leg1),
        .leg2  (w_leg2),
        .legal (w_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_resp  <= RESP_DONE;
            r_trmt  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_idx   <= w_nxt_idx;
            r_resp  <= w_nxt_resp;
            r_trmt  <= (w_nxt == RESP);
        end
    end

    // Coincident clear+completion in a leg skips the matching wait state.
    always_comb begin
        w_nxt      = r_state;
        w_nxt_idx  = r_idx;
        w_nxt_resp = r_resp;
        case (r_state)
            IDLE: begin
                if (tour_go) begin
                    w_nxt     = LEG1;
                    w_nxt_idx = '0;
                end
            end
            LEG1: begin
                if (!w_legal) begin
                    w_nxt      = RESP;
                    w_nxt_resp = RESP_ABORT;
                end else if (clr_cmd_rdy) begin
                    w_nxt = send_resp ? LEG2 : WAIT1;
                end
            end
            WAIT1: if (send_resp) w_nxt = LEG2;
            LEG2:  if (clr_cmd_rdy) w_nxt = send_resp ? NEXT : WAIT2;
            WAIT2: if (send_resp) w_nxt = NEXT;
            NEXT: begin
                if (r_idx == c_LAST) begin
                    w_nxt      = RESP;
                    w_nxt_resp = RESP_DONE;
                end else begin
                    w_nxt_idx = r_idx + c_ONE;
`ifdef TOUR_PROGRESS_RESP_EN
                    w_nxt      = RESP;
                    w_nxt_resp = RESP_PROG;
`else
                    w_nxt = LEG1;
`endif
                end
            end
            RESP: begin
                if (r_resp == RESP_PROG) begin
                    w_nxt = LEG1;
                end else begin
                    w_nxt     = IDLE;
                    w_nxt_idx = '0;
                end
            end
            default: w_nxt = IDLE;
        endcase
    end

    // Outputs are forced to their reset values while rst is high.
    always_comb begin
        cmd              = 16'h0000;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = r_resp;
        trmt             = r_trmt;
        if (rst) begin
            resp = RESP_DONE;
            trmt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    cmd              = cmd_UART;
                    cmd_rdy          = cmd_rdy_UART;
                    clr_cmd_rdy_UART = clr_cmd_rdy;
                    resp             = RESP_DONE;
                    trmt             = send_resp;
                end
                LEG1: begin
                    cmd     = {MOVE, w_leg1};
                    cmd_rdy = w_legal;
                end
                WAIT1: cmd = {MOVE, w_leg1};
                LEG2: begin
                    cmd     = {MOVE_FF, w_leg2};
                    cmd_rdy = 1'b1;
                end
                WAIT2: cmd = {MOVE_FF, w_leg2};
                default: ;
            endcase
        end
    end

    assign mv_indx = r_idx;

endmodule
`default_nettype wire
